// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: funct3 width codes, opcodes and LSU states.
// Imported by the load/store unit and its byte-lane helper.
package rv32_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUS,
        LSU_RESP
    } lsu_state_e;

endpackage

// File: rtl/rv32_lsu_align.sv
// Byte-lane helper: strobes, lane replication, access legality
// and load-data extraction/extension for one RV32 access.
module rv32_lsu_align
    import rv32_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  strb,
    output logic [31:0] wdata_rep,
    output logic        illegal,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Decode width: strobe, replicated store data, legality.
    always_comb begin
        strb       = 4'b0000;
        wdata_rep  = wdata;
        illegal    = 1'b0;
        misaligned = 1'b0;
        case (funct3)
            F3_B: begin
                strb      = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            F3_H: begin
                strb       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep  = {2{wdata[15:0]}};
                misaligned = addr_lo[0];
            end
            F3_W: begin
                strb       = 4'b1111;
                misaligned = |addr_lo;
            end
            F3_BU: illegal = we;
            F3_HU: begin
                illegal    = we;
                misaligned = addr_lo[0];
            end
            default: illegal = 1'b1;
        endcase
        if (!we) begin
            strb = 4'b0000;
        end
    end

    // Select the addressed byte/halfword and extend it.
    always_comb begin
        rdata_ext = 32'h0;
        case (funct3)
            F3_B:    rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            F3_H:    rdata_ext = {{16{rd_half[15]}}, rd_half};
            F3_W:    rdata_ext = rdata;
            F3_BU:   rdata_ext = {24'h0, rd_byte};
            F3_HU:   rdata_ext = {16'h0, rd_half};
            default: rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32_lsu_bs.sv
// RV32 load/store unit: turns core accesses into word-aligned
// strobed bus transfers with wait-state handling and a timeout.
module rv32_lsu_bs
    import rv32_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e state;
    lsu_state_e state_n;

    logic            lat_we;
    logic [2:0]      lat_f3;
    logic [1:0]      lat_lo;
    logic [TO_W-1:0] to_cnt;

    logic        idle;
    logic        accept;
    logic        bad;
    logic        to_fire;
    logic        a_we;
    logic [2:0]  a_f3;
    logic [1:0]  a_lo;
    logic [3:0]  al_strb;
    logic [31:0] al_wdata;
    logic        al_illegal;
    logic        al_misaligned;
    logic [31:0] al_rdata;

    assign idle       = (state == LSU_IDLE);
    assign req_ready  = idle;
    assign mem_valid  = (state == LSU_BUS);
    assign resp_valid = (state == LSU_RESP);
    assign accept     = req_valid & idle;
    assign bad        = al_illegal | al_misaligned;
    assign to_fire    = TO_EN && (to_cnt == TO_LAST);

    // The helper sees the live request while idle, the held one after.
    assign a_we = idle ? req_we          : lat_we;
    assign a_f3 = idle ? req_funct3      : lat_f3;
    assign a_lo = idle ? req_addr[1:0]   : lat_lo;

    rv32_lsu_align u_align (
        .we         (a_we),
        .funct3     (a_f3),
        .addr_lo    (a_lo),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .strb       (al_strb),
        .wdata_rep  (al_wdata),
        .illegal    (al_illegal),
        .misaligned (al_misaligned),
        .rdata_ext  (al_rdata)
    );

    // State register; reset abandons any bus transfer at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= LSU_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state: errors skip the bus, ready beats the timeout.
    always_comb begin
        state_n = state;
        case (state)
            LSU_IDLE: begin
                if (accept) begin
                    state_n = bad ? LSU_RESP : LSU_BUS;
                end
            end
            LSU_BUS: begin
                if (mem_ready || to_fire) begin
                    state_n = LSU_RESP;
                end
            end
            LSU_RESP: state_n = LSU_IDLE;
            default:  state_n = LSU_IDLE;
        endcase
    end

    // Request latch, bus drive registers, timeout count and response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_we     <= 1'b0;
            lat_f3     <= 3'b000;
            lat_lo     <= 2'b00;
            to_cnt     <= '0;
            mem_addr   <= 32'h0;
            mem_we     <= 4'b0000;
            mem_wdata  <= 32'h0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (accept) begin
                        lat_we    <= req_we;
                        lat_f3    <= req_funct3;
                        lat_lo    <= req_addr[1:0];
                        to_cnt    <= '0;
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_we    <= al_strb;
                        mem_wdata <= al_wdata;
                        if (bad) begin
                            resp_rdata <= 32'h0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                LSU_BUS: begin
                    if (mem_ready) begin
                        resp_rdata <= lat_we ? 32'h0 : al_rdata;
                        resp_err   <= 1'b0;
                    end else if (to_fire) begin
                        resp_rdata <= 32'h0;
                        resp_err   <= 1'b1;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/rv32_lsu_bs.md
Name: rv32_lsu_bs

Overview:
Load/store unit sitting directly downstream of the core's memory stage, between the core's data-access request and the data memory / MMIO bus. It translates byte, halfword and word accesses into word-aligned bus transfers with byte-lane strobes. It handles variable-latency memory through a valid/ready handshake, and returns sign- or zero-extended load data. Misaligned accesses, illegal funct3 values and bus timeouts are reported as errors.

Parameters:
TIMEOUT_CYCLES, 255, number of cycles to wait for mem_ready before aborting; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
req_valid  input  1  core presents an access
req_ready  output  1  LSU can accept; high only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle pulse: access finished
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  valid with resp_valid: misaligned, illegal funct3 or timeout
mem_valid  output  1  bus request
mem_ready  input  1  bus completes the transfer in the cycle it is sampled high with mem_valid
mem_addr  output  32  {req_addr[31:2],2'b00}
mem_we  output  4  byte strobes; 0000 = read
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  read word, valid when mem_ready=1

Behaviour:
- Reset (async, rstn=0): state IDLE. All outputs are 0 except req_ready=1. The timeout counter is cleared.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - On req_valid&req_ready, latch the request.
  - If the request is illegal or misaligned, go to RESP with err=1. No bus cycle is issued.
  - Otherwise go to BUS.
- Illegal funct3:
  - Loads: 011, 110, 111.
  - Stores: any value >= 011.
- Misaligned:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]!=00.
- BUS:
  - mem_valid=1. mem_addr, mem_we and mem_wdata are registered and held stable until mem_ready.
  - On mem_ready: capture and extend rdata (loads), go to RESP with err=0.
  - The counter increments each BUS cycle without mem_ready. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0): drop mem_valid, go to RESP with err=1, rdata=0.
  - mem_ready arriving in the same cycle the timeout fires takes priority: the access completes normally.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err hold until the next resp_valid.
- Latency:
  - Zero-wait memory (mem_ready high in the first BUS cycle): accept at edge N, mem_valid during cycle N+1, resp_valid during cycle N+2.
  - Each wait cycle adds one cycle.
  - Error path: resp_valid during cycle N+1.
- req_valid while not in IDLE is ignored; there is no queueing. The core must hold req_* until acceptance.
- Byte-lane rules:
  - SB: mem_we = 0001<<addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
  - SH: mem_we = 0011<<{addr[1],0}; mem_wdata = {2{wdata[15:0]}}.
  - SW: mem_we = 1111; mem_wdata = wdata.
  - Loads: mem_we = 0000.
- Load extension:
  - Select the byte rdata[8*addr[1:0]+:8] or the halfword rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW is a pass-through.
- Reset mid-BUS: mem_valid drops asynchronously. The transfer is abandoned and no resp_valid is generated. The bus slave must tolerate the abandoned request.

Decomposition:
- Shared package rv32_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - LSU state encoding.
  - Opcode constants shared with the core.
- One combinational sub-module, rv32_lsu_align:
  - Computes strobe, replicated wdata, misaligned/illegal flags and load extraction/extension from funct3, addr[1:0] and data.
  - The top level holds the FSM, registers and timeout counter.

Test Plan:
- SB addr=0x0000_0103, wdata=0x0000_00A5, mem_ready tied 1 -> mem_addr=0x100, mem_we=1000, mem_wdata=0xA5A5A5A5; resp_valid 2 cycles after accept, err=0, rdata=0.
- LH addr=0x202, mem_rdata=0x8001_1234, 3 wait cycles -> resp_rdata=0xFFFF8001, resp_valid 5 cycles after accept; repeat with LHU -> 0x00008001.
- LB addr=0x1, mem_rdata=0x0000_7F00 -> resp_rdata=0x0000007F; LW addr=0x6 -> resp_err=1 one cycle after accept, mem_valid never asserted.
- Store funct3=011 -> resp_err=1, no bus cycle; next legal LW is accepted immediately afterwards.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high 4 cycles then low, resp_err=1, resp_rdata=0; variant with mem_ready arriving on cycle 4 -> normal completion, err=0.
- Assert rstn low during BUS -> mem_valid=0 and req_ready=1 immediately; no resp_valid pulse after reset release; a following SW completes normally.
